// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream mux/arbiter: FSM states and arbitration modes.
package hwpe_stream_package;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic {
        STATIC = 1'b0,
        RR     = 1'b1
    } mode_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes; sink receives data, source drives it.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport sink   (input valid, input data, input strb, output ready);
    modport source (output valid, output data, output strb, input ready);
endinterface

// File: rtl/hwpe_stream_rr_select.sv
// Rotating-priority search: first set valid bit at or after the start pointer, with wrap.
module hwpe_stream_rr_select #(
    parameter int unsigned NB_IN = 4
) (
    input  logic [NB_IN-1:0]         valid,
    input  logic [$clog2(NB_IN)-1:0] start,
    output logic [$clog2(NB_IN)-1:0] idx,
    output logic                     found
);
    localparam int unsigned IDX_W = $clog2(NB_IN);

    int unsigned pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            pos = 32'(start) + i;
            if (pos >= NB_IN) pos = pos - NB_IN;
            if (!found && valid[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/hwpe_stream_mux_arbiter.sv
// Burst-granting N:1 stream mux with static or round-robin selection and a
// registered output stage; one idle arbitration cycle separates consecutive bursts.
module hwpe_stream_mux_arbiter
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     mode_i,
    input  logic [$clog2(NB_IN)-1:0] sel_i,
    input  logic [BURST_W-1:0]       burst_len_i,
    hwpe_stream_intf_stream.sink     push_i [NB_IN],
    hwpe_stream_intf_stream.source   pop_o,
    output logic                     grant_valid_o,
    output logic [$clog2(NB_IN)-1:0] grant_idx_o
);
    localparam int unsigned IDX_W      = $clog2(NB_IN);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NB_IN-1:0]      in_valid;
    logic [NB_IN-1:0]      in_ready;
    logic [DATA_WIDTH-1:0] in_data [NB_IN];
    logic [STRB_WIDTH-1:0] in_strb [NB_IN];

    // Interface arrays only accept constant indices, so flatten them here.
    for (genvar k = 0; k < NB_IN; k++) begin : g_flat
        assign in_valid[k]    = push_i[k].valid;
        assign in_data[k]     = push_i[k].data;
        assign in_strb[k]     = push_i[k].strb;
        assign push_i[k].ready = in_ready[k];
    end

    state_e                state_q, state_d;
    mode_e                 mode;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_q;
    logic [BURST_W-1:0]    cnt_q;
    logic [BURST_W-1:0]    len_q, len_d;
    logic [IDX_W-1:0]      rr_start;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_found;
    logic                  accept;
    logic                  push_hs;
    logic                  last_beat;
    logic                  pop_hs;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [STRB_WIDTH-1:0] out_strb_q;

    assign mode     = mode_e'(mode_i);
    assign rr_start = (last_q == IDX_W'(NB_IN - 1)) ? '0 : last_q + 1'b1;
    assign accept   = ~out_valid_q | pop_o.ready;
    assign pop_hs   = out_valid_q & pop_o.ready;

    hwpe_stream_rr_select #(
        .NB_IN (NB_IN)
    ) i_rr_select (
        .valid (in_valid),
        .start (rr_start),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Arbitration and burst tracking; request parameters are only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        len_d     = len_q;
        in_ready  = '0;
        push_hs   = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode == RR) begin
                    if (rr_found) begin
                        grant_d = rr_idx;
                        state_d = BURST;
                    end
                end else if (32'(sel_i) < NB_IN) begin
                    grant_d = sel_i;
                    state_d = BURST;
                end
                if (state_d == BURST) begin
                    len_d = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
                end
            end
            BURST: begin
                in_ready[grant_q] = accept;
                push_hs           = in_valid[grant_q] & accept;
                last_beat         = push_hs && (cnt_q == len_q - BURST_W'(1));
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NB_IN - 1);
        end else if (clear_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(NB_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            if (last_beat) begin
                cnt_q  <= '0;
                last_q <= grant_q;
            end else if (push_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A new beat overwrites the register even while it is being popped, giving full throughput.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
        end else if (clear_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
        end else if (push_hs) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data[grant_q];
            out_strb_q  <= in_strb[grant_q];
        end else if (pop_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    assign pop_o.valid   = out_valid_q;
    assign pop_o.data    = out_data_q;
    assign pop_o.strb    = out_strb_q;
    assign grant_valid_o = (state_q == BURST);
    assign grant_idx_o   = grant_q;
endmodule

// File: tb/tb_hwpe_stream_mux_arbiter.sv
// Directed self-checking bench for hwpe_stream_mux_arbiter (4-input main DUT, 3-input DUT for out-of-range select).
module tb_hwpe_stream_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  burst_len;
    logic        pop_ready;
    logic        grant_valid;
    logic [1:0]  grant_idx;

    logic [3:0]  src_en;
    int          beats [4];
    int          limit [4];
    logic [31:0] base  [4];
    logic [3:0]  src_valid;
    logic [31:0] src_data [4];
    logic [3:0]  src_ready;
    logic [3:0]  hs;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [2:0]  b_ready;
    logic        b_grant_valid;
    logic [1:0]  b_grant_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if [4] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) b_push_if [3] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) b_pop_if ();

    for (genvar k = 0; k < 4; k++) begin : g_src
        assign push_if[k].valid = src_valid[k];
        assign push_if[k].data  = src_data[k];
        assign push_if[k].strb  = src_data[k][3:0];
        assign src_ready[k]     = push_if[k].ready;
    end

    for (genvar k = 0; k < 3; k++) begin : g_b_src
        assign b_push_if[k].valid = 1'b1;
        assign b_push_if[k].data  = 32'hD0 + k;
        assign b_push_if[k].strb  = 4'hF;
        assign b_ready[k]         = b_push_if[k].ready;
    end

    assign pop_if.ready   = pop_ready;
    assign b_pop_if.ready = 1'b1;

    hwpe_stream_mux_arbiter #(
        .NB_IN      (4),
        .DATA_WIDTH (32),
        .BURST_W    (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .mode_i        (mode),
        .sel_i         (sel),
        .burst_len_i   (burst_len),
        .push_i        (push_if),
        .pop_o         (pop_if),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    hwpe_stream_mux_arbiter #(
        .NB_IN      (3),
        .DATA_WIDTH (32),
        .BURST_W    (8)
    ) dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (1'b0),
        .mode_i        (b_mode),
        .sel_i         (b_sel),
        .burst_len_i   (8'd1),
        .push_i        (b_push_if),
        .pop_o         (b_pop_if),
        .grant_valid_o (b_grant_valid),
        .grant_idx_o   (b_grant_idx)
    );

    task automatic update_sources();
        for (int k = 0; k < 4; k++) begin
            src_valid[k] = src_en[k] && (beats[k] < limit[k]);
            src_data[k]  = base[k] + 32'(beats[k]);
        end
    endtask

    task automatic cycle_end();
        hs = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) beats[k] = beats[k] + 1;
        end
        update_sources();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clear     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        burst_len = 8'd1;
        pop_ready = 1'b1;
        src_en    = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            beats[k] = 0;
            limit[k] = 1000;
            base[k]  = 32'h0;
        end
        update_sources();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (pop_if.valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pop_valid got=%0b exp=0", pop_if.valid);
        end
        checks++;
        if (pop_if.data !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_pop_data got=%h exp=0", pop_if.data);
        end
        checks++;
        if (pop_if.strb !== 4'h0) begin
            failures++; $display("[TB] FAIL reset_pop_strb got=%h exp=0", pop_if.strb);
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_grant_valid got=%0b exp=0", grant_valid);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            failures++; $display("[TB] FAIL reset_grant_idx got=%0d exp=0", grant_idx);
        end
        checks++;
        if (src_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_push_ready got=%b exp=0000", src_ready);
        end
    endtask

    task automatic test_static_burst();
        logic [8:0]  exp_v = 9'b011011100;
        logic [31:0] exp_d [9] = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0, 32'hA3, 32'hA4, 32'h0};
        logic [31:0] d;
        do_reset();
        mode      = 1'b0;
        sel       = 2'd2;
        burst_len = 8'd3;
        base[2]   = 32'hA0;
        limit[2]  = 5;
        base[0]   = 32'h11;
        src_en    = 4'b0101;
        update_sources();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            d = exp_d[c];
            checks++;
            if (pop_if.valid !== exp_v[c]) begin
                failures++; $display("[TB] FAIL static_valid c=%0d got=%0b exp=%0b", c, pop_if.valid, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (pop_if.data !== d) begin
                    failures++; $display("[TB] FAIL static_data c=%0d got=%h exp=%h", c, pop_if.data, d);
                end
                checks++;
                if (pop_if.strb !== d[3:0]) begin
                    failures++; $display("[TB] FAIL static_strb c=%0d got=%h exp=%h", c, pop_if.strb, d[3:0]);
                end
            end
            checks++;
            if (src_ready[0] !== 1'b0) begin
                failures++; $display("[TB] FAIL static_in0_ready c=%0d got=%0b exp=0", c, src_ready[0]);
            end
            cycle_end();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_r;
        logic [31:0] exp_d;
        int          m;
        do_reset();
        mode      = 1'b1;
        burst_len = 8'd1;
        for (int k = 0; k < 4; k++) base[k] = 32'hC000_0000 + 32'(k * 256);
        src_en = 4'b1111;
        update_sources();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            exp_r = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
            checks++;
            if (src_ready !== exp_r) begin
                failures++; $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, src_ready, exp_r);
            end
            if (c % 2 == 1) begin
                checks++;
                if (grant_idx !== 2'(((c - 1) / 2) % 4) || grant_valid !== 1'b1) begin
                    failures++; $display("[TB] FAIL rr_grant c=%0d got=%0d/%0b exp=%0d/1", c, grant_idx, grant_valid, ((c - 1) / 2) % 4);
                end
            end
            if (c % 2 == 0 && c >= 2) begin
                m     = (c - 2) / 2;
                exp_d = 32'hC000_0000 + 32'((m % 4) * 256) + 32'(m / 4);
                checks++;
                if (pop_if.valid !== 1'b1 || pop_if.data !== exp_d) begin
                    failures++; $display("[TB] FAIL rr_pop c=%0d got=%0b/%h exp=1/%h", c, pop_if.valid, pop_if.data, exp_d);
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode      = 1'b0;
        sel       = 2'd1;
        burst_len = 8'd4;
        base[1]   = 32'h55;
        src_en    = 4'b0010;
        pop_ready = 1'b0;
        update_sources();
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL bp_idle_ready got=%b exp=0000", src_ready);
        end
        cycle_end();
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0010) begin
            failures++; $display("[TB] FAIL bp_first_ready got=%b exp=0010", src_ready);
        end
        cycle_end();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (pop_if.valid !== 1'b1 || pop_if.data !== 32'h55) begin
                failures++; $display("[TB] FAIL bp_hold c=%0d got=%0b/%h exp=1/55", c, pop_if.valid, pop_if.data);
            end
            checks++;
            if (src_ready !== 4'b0000) begin
                failures++; $display("[TB] FAIL bp_stall_ready c=%0d got=%b exp=0000", c, src_ready);
            end
            cycle_end();
        end
        pop_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0010 || pop_if.data !== 32'h55) begin
            failures++; $display("[TB] FAIL bp_release got=%b/%h exp=0010/55", src_ready, pop_if.data);
        end
        cycle_end();
        @(negedge clk);
        checks++;
        if (pop_if.valid !== 1'b1 || pop_if.data !== 32'h56) begin
            failures++; $display("[TB] FAIL bp_next_beat got=%0b/%h exp=1/56", pop_if.valid, pop_if.data);
        end
    endtask

    task automatic test_zero_len();
        logic [5:0] exp_r = 6'b101010;
        do_reset();
        mode      = 1'b0;
        sel       = 2'd3;
        burst_len = 8'd0;
        base[3]   = 32'h300;
        src_en    = 4'b1000;
        update_sources();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (src_ready[3] !== exp_r[c] || grant_valid !== exp_r[c]) begin
                failures++; $display("[TB] FAIL zero_len c=%0d got=%0b/%0b exp=%0b", c, src_ready[3], grant_valid, exp_r[c]);
            end
            cycle_end();
        end
    endtask

    task automatic test_out_of_range();
        b_mode = 1'b0;
        b_sel  = 2'd3;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (b_grant_valid !== 1'b0 || b_ready !== 3'b000 || b_pop_if.valid !== 1'b0) begin
                failures++; $display("[TB] FAIL oor c=%0d got=%0b/%b/%0b exp=0/000/0", c, b_grant_valid, b_ready, b_pop_if.valid);
            end
            cycle_end();
        end
        b_mode = 1'b1;
    endtask

    task automatic test_clear();
        do_reset();
        mode      = 1'b1;
        burst_len = 8'd1;
        base[2]   = 32'h200;
        src_en    = 4'b0100;
        update_sources();
        @(negedge clk);
        cycle_end();
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0100) begin
            failures++; $display("[TB] FAIL clr_first_ready got=%b exp=0100", src_ready);
        end
        cycle_end();
        burst_len = 8'd4;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL clr_bubble got=%0b exp=0", grant_valid);
        end
        cycle_end();
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b0100 || grant_idx !== 2'd2) begin
            failures++; $display("[TB] FAIL clr_second_grant got=%b/%0d exp=0100/2", src_ready, grant_idx);
        end
        cycle_end();
        @(negedge clk);
        checks++;
        if (pop_if.valid !== 1'b1 || pop_if.data !== 32'h201) begin
            failures++; $display("[TB] FAIL clr_before got=%0b/%h exp=1/201", pop_if.valid, pop_if.data);
        end
        clear  = 1'b1;
        src_en = 4'b1111;
        update_sources();
        cycle_end();
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (pop_if.valid !== 1'b0 || grant_valid !== 1'b0 || src_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL clr_after got=%0b/%0b/%b exp=0/0/0000", pop_if.valid, grant_valid, src_ready);
        end
        cycle_end();
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || src_ready !== 4'b0001) begin
            failures++; $display("[TB] FAIL clr_rr_restart got=%0b/%0d/%b exp=1/0/0001", grant_valid, grant_idx, src_ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode      = 1'b0;
        sel       = 2'd0;
        burst_len = 8'd4;
        base[0]   = 32'h77;
        src_en    = 4'b0001;
        update_sources();
        cycle_end();
        cycle_end();
        #2;
        checks++;
        if (pop_if.valid !== 1'b1 || pop_if.data !== 32'h77) begin
            failures++; $display("[TB] FAIL arst_before got=%0b/%h exp=1/77", pop_if.valid, pop_if.data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pop_if.valid !== 1'b0 || grant_valid !== 1'b0 || src_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL arst_immediate got=%0b/%0b/%b exp=0/0/0000", pop_if.valid, grant_valid, src_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        b_mode = 1'b1;
        b_sel  = 2'd0;
        test_reset();
        test_static_burst();
        test_round_robin();
        test_backpressure();
        test_zero_len();
        test_out_of_range();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
